// File: rtl/rule_cfg_arbiter.sv
// rule_cfg_arbiter
// Round-robin arbiter that shares the per-layer rule configuration port of a
// parser pipeline between several configuration masters. One request is in
// flight at a time: accept (IDLE) -> single-cycle strobe (ISSUE) ->
// optional wait for read data (WAIT_RD) -> single-cycle response (RESP).
// Optional feature macro: RULE_BROADCAST_EN (layer index 4'hF writes all layers).
module rule_cfg_arbiter #(
  parameter int REQ_NUM    = 2,
  parameter int LAYER_NUM  = 4,
  parameter int LSEL_LSB   = 24,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [REQ_NUM-1:0]              i_req_valid,
  input  logic [REQ_NUM-1:0]              i_req_wr,
  input  logic [REQ_NUM-1:0][31:0]        i_req_addr,
  input  logic [REQ_NUM-1:0][31:0]        i_req_wdata,
  output logic [REQ_NUM-1:0]              o_req_ready,
  output logic [REQ_NUM-1:0]              o_resp_valid,
  output logic [31:0]                     o_resp_data,
  output logic                            o_resp_err,
  output logic [LAYER_NUM-1:0]            o_rule_wren,
  output logic [LAYER_NUM-1:0]            o_rule_rden,
  output logic [31:0]                     o_rule_addr,
  output logic [31:0]                     o_rule_wdata,
  input  logic [LAYER_NUM-1:0]            i_rule_rdata_valid,
  input  logic [LAYER_NUM-1:0][31:0]      i_rule_rdata
);

  localparam int LSEL_W = 4;
  localparam int PTR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  // Last WAIT_RD count value before the read is declared lost.
  localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

  logic [1:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic [7:0]           cnt;

  logic                 hi_any;
  logic                 lo_any;
  logic [PTR_W-1:0]     hi_idx;
  logic [PTR_W-1:0]     lo_idx;
  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx;

  logic [LSEL_W-1:0]    lsel;
  logic [LAYER_NUM-1:0] hit;
  logic                 in_range;
  logic                 bcast;
  logic                 issue_err;
  logic                 sel_valid;
  logic [31:0]          sel_data;

  // Round-robin search: lowest valid index at/after the pointer, else lowest below it.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int r = REQ_NUM - 1; r >= 0; r--) begin
      if (i_req_valid[r] && (PTR_W'(r) >= ptr)) begin
        hi_any = 1'b1;
        hi_idx = PTR_W'(r);
      end else if (i_req_valid[r]) begin
        lo_any = 1'b1;
        lo_idx = PTR_W'(r);
      end else begin
        lo_any = lo_any;
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  // Layer decode from the captured address and read-data mux for the selected layer.
  always_comb begin
    lsel      = addr_q[LSEL_LSB +: LSEL_W];
    hit       = '0;
    sel_valid = 1'b0;
    sel_data  = 32'd0;
    for (int l = 0; l < LAYER_NUM; l++) begin
      if (lsel == LSEL_W'(l)) begin
        hit[l]    = 1'b1;
        sel_valid = i_rule_rdata_valid[l];
        sel_data  = i_rule_rdata[l];
      end else begin
        hit[l]    = 1'b0;
      end
    end
    in_range = |hit;
`ifdef RULE_BROADCAST_EN
    bcast = (lsel == 4'hF);
`else
    bcast = 1'b0;
`endif
    // Broadcast only makes sense for writes; otherwise an unmapped index is an error.
    issue_err = bcast ? ~wr_q : ~in_range;
  end

  // Request accept and response strobes; ready is the only input-dependent output.
  always_comb begin
    if ((state == S_IDLE) && gnt_any && !i_rst) begin
      o_req_ready = REQ_NUM'(1'b1) << gnt_idx;
    end else begin
      o_req_ready = '0;
    end
    if (state == S_RESP) begin
      o_resp_valid = REQ_NUM'(1'b1) << gnt_q;
    end else begin
      o_resp_valid = '0;
    end
  end

  // Single-cycle layer strobes in ISSUE, suppressed for erroring requests.
  always_comb begin
    o_rule_wren = '0;
    o_rule_rden = '0;
    if ((state == S_ISSUE) && !issue_err) begin
      if (wr_q) begin
        o_rule_wren = bcast ? {LAYER_NUM{1'b1}} : hit;
      end else begin
        o_rule_rden = hit;
      end
    end else begin
      o_rule_wren = '0;
    end
  end

  // Shared address/data come straight from the captured request so they hold through RESP.
  always_comb begin
    o_rule_addr  = addr_q;
    o_rule_wdata = wdata_q;
  end

  // Transaction FSM: capture, issue, wait for read data with timeout, respond.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      gnt_q       <= '0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wr_q        <= 1'b0;
      cnt         <= 8'd0;
      o_resp_data <= 32'd0;
      o_resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            gnt_q   <= gnt_idx;
            addr_q  <= i_req_addr[gnt_idx];
            wdata_q <= i_req_wdata[gnt_idx];
            wr_q    <= i_req_wr[gnt_idx];
            if (gnt_idx == PTR_W'(REQ_NUM - 1)) begin
              ptr <= '0;
            end else begin
              ptr <= gnt_idx + PTR_W'(1);
            end
            state   <= S_ISSUE;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (issue_err) begin
            o_resp_data <= 32'd0;
            o_resp_err  <= 1'b1;
            state       <= S_RESP;
          end else if (wr_q) begin
            o_resp_data <= 32'd0;
            o_resp_err  <= 1'b0;
            state       <= S_RESP;
          end else if (sel_valid) begin
            o_resp_data <= sel_data;
            o_resp_err  <= 1'b0;
            state       <= S_RESP;
          end else begin
            cnt         <= 8'd0;
            state       <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          // Data arriving on the expiry cycle still wins over the timeout.
          if (sel_valid) begin
            o_resp_data <= sel_data;
            o_resp_err  <= 1'b0;
            state       <= S_RESP;
          end else if (cnt == TO_LAST) begin
            o_resp_data <= 32'd0;
            o_resp_err  <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt         <= cnt + 8'd1;
            state       <= S_WAIT_RD;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rule_cfg_arbiter.sv
// Directed self-checking bench for rule_cfg_arbiter (REQ_NUM=2, LAYER_NUM=4,
// RD_TIMEOUT=15). Layer model: per-layer constant read data, valid either
// combinational from rden (comb_en) or driven late by the bench (late_vld).
module tb_rule_cfg_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_wr;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic [3:0]        wren;
  logic [3:0]        rden;
  logic [31:0]       rule_addr;
  logic [31:0]       rule_wdata;
  logic [3:0]        rdata_valid;
  logic [3:0][31:0]  layer_data;
  logic [3:0]        comb_en;
  logic [3:0]        late_vld;

  int n_asrt = 0;
  int n_fail = 0;

`ifdef RULE_BROADCAST_EN
  localparam logic [3:0] BC_WREN = 4'b1111;
  localparam logic       BC_ERR  = 1'b0;
`else
  localparam logic [3:0] BC_WREN = 4'b0000;
  localparam logic       BC_ERR  = 1'b1;
`endif

  always #5 clk = ~clk;

  assign rdata_valid = (rden & comb_en) | late_vld;

  rule_cfg_arbiter #(
    .REQ_NUM(2), .LAYER_NUM(4), .LSEL_LSB(24), .RD_TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(req_valid),
    .i_req_wr(req_wr),
    .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_req_ready(req_ready),
    .o_resp_valid(resp_valid),
    .o_resp_data(resp_data),
    .o_resp_err(resp_err),
    .o_rule_wren(wren),
    .o_rule_rden(rden),
    .o_rule_addr(rule_addr),
    .o_rule_wdata(rule_wdata),
    .i_rule_rdata_valid(rdata_valid),
    .i_rule_rdata(layer_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         g;
    int         cnt [2];
    logic [1:0] exp_oh;
    logic [31:0] exp_wd;

    rst = 1'b1;
    req_valid = 2'b00;
    req_wr = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    comb_en = 4'b0000;
    late_vld = 4'b0000;
    layer_data[0] = 32'hD000_0000;
    layer_data[1] = 32'hD111_1111;
    layer_data[2] = 32'h1234_5678;
    layer_data[3] = 32'hD333_3333;
    cnt[0] = 0;
    cnt[1] = 0;

    // Reset state, with a request pending that must not be accepted
    req_valid = 2'b01;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_rden", 32'(rden), 32'd0);
    chk("rst_addr", rule_addr, 32'd0);
    chk("rst_wdata", rule_wdata, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    step();

    // Test 1: req0 write to layer 1
    req_addr[0] = 32'h0100_0010;
    req_wdata[0] = 32'hA5A5_0001;
    req_wr = 2'b01;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("t1_wren", 32'(wren), 32'h2);
    chk("t1_rden", 32'(rden), 32'h0);
    chk("t1_addr", rule_addr, 32'h0100_0010);
    chk("t1_wdata", rule_wdata, 32'hA5A5_0001);
    chk("t1_ready_issue", 32'(req_ready), 32'h0);
    chk("t1_no_resp", 32'(resp_valid), 32'h0);
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_err", 32'(resp_err), 32'h0);
    chk("t1_resp_data", resp_data, 32'h0);
    chk("t1_wren_off", 32'(wren), 32'h0);
    chk("t1_addr_resp", rule_addr, 32'h0100_0010);
    step();
    chk("t1_resp_done", 32'(resp_valid), 32'h0);

    // Test 2: req1 read of layer 2, data valid combinationally
    req_addr[1] = 32'h0200_0000;
    req_wr = 2'b00;
    comb_en = 4'b0100;
    req_valid = 2'b10;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    chk("t2_rden", 32'(rden), 32'h4);
    chk("t2_wren", 32'(wren), 32'h0);
    step();
    chk("t2_resp_valid", 32'(resp_valid), 32'h2);
    chk("t2_resp_data", resp_data, 32'h1234_5678);
    chk("t2_resp_err", 32'(resp_err), 32'h0);
    step();
    chk("t2_resp_done", 32'(resp_valid), 32'h0);
    chk("t2_data_hold", resp_data, 32'h1234_5678);
    comb_en = 4'b0000;

    // Test 3: both requesters continuously valid, 4 writes each
    req_wr = 2'b11;
    req_addr[0] = 32'h0000_0004;
    req_addr[1] = 32'h0100_0008;
    req_wdata[0] = 32'hC0DE_0000;
    req_wdata[1] = 32'hC0DE_0100;
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      g = i % 2;
      exp_oh = 2'b01 << g;
      exp_wd = req_wdata[g];
      #1;
      chk("rr_ready", 32'(req_ready), 32'(exp_oh));
      step();
      cnt[g] = cnt[g] + 1;
      req_wdata[g] = 32'hC0DE_0000 | 32'(g << 8) | 32'(cnt[g]);
      if (cnt[g] == 4) req_valid[g] = 1'b0;
      chk("rr_wren", 32'(wren), 32'(exp_oh));
      chk("rr_wdata", rule_wdata, exp_wd);
      chk("rr_ready_issue", 32'(req_ready), 32'h0);
      step();
      chk("rr_resp_valid", 32'(resp_valid), 32'(exp_oh));
      chk("rr_ready_resp", 32'(req_ready), 32'h0);
      step();
    end
    chk("rr_idle_resp", 32'(resp_valid), 32'h0);

    // Test 4: read of layer 3 that never gets data -> timeout at T+17
    req_addr[0] = 32'h0300_0000;
    req_wr = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("to_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("to_rden", 32'(rden), 32'h8);
    for (int c = 2; c <= 16; c++) begin
      step();
      chk("to_wait_resp", 32'(resp_valid), 32'h0);
      chk("to_wait_rden", 32'(rden), 32'h0);
    end
    step();
    chk("to_resp_valid", 32'(resp_valid), 32'h1);
    chk("to_resp_err", 32'(resp_err), 32'h1);
    chk("to_resp_data", resp_data, 32'h0);
    step();
    chk("to_resp_done", 32'(resp_valid), 32'h0);

    // Test 4b: valid arriving on the expiry cycle wins (req1, layer 3)
    req_addr[1] = 32'h0300_0000;
    req_valid = 2'b10;
    #1;
    chk("exp_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    for (int c = 2; c <= 15; c++) begin
      step();
      chk("exp_wait_resp", 32'(resp_valid), 32'h0);
    end
    step();
    late_vld = 4'b1000;
    chk("exp_wait_last", 32'(resp_valid), 32'h0);
    step();
    late_vld = 4'b0000;
    chk("exp_resp_valid", 32'(resp_valid), 32'h2);
    chk("exp_resp_err", 32'(resp_err), 32'h0);
    chk("exp_resp_data", resp_data, 32'hD333_3333);
    step();

    // Test 4c: read of layer 1 with data 3 cycles after rden -> response at T+5
    req_addr[0] = 32'h0100_0000;
    req_valid = 2'b01;
    #1;
    chk("late_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("late_rden", 32'(rden), 32'h2);
    step();
    chk("late_wait2", 32'(resp_valid), 32'h0);
    step();
    chk("late_wait3", 32'(resp_valid), 32'h0);
    step();
    late_vld = 4'b0010;
    chk("late_wait4", 32'(resp_valid), 32'h0);
    chk("late_rden_off", 32'(rden), 32'h0);
    step();
    late_vld = 4'b0000;
    chk("late_resp_valid", 32'(resp_valid), 32'h1);
    chk("late_resp_data", resp_data, 32'hD111_1111);
    chk("late_resp_err", 32'(resp_err), 32'h0);
    step();

    // Stray read-data valid while idle is ignored
    late_vld = 4'b1111;
    step();
    step();
    chk("stray_resp", 32'(resp_valid), 32'h0);
    late_vld = 4'b0000;

    // Test 5: write to unmapped layer 9 from req1
    req_addr[1] = 32'h0900_0000;
    req_wr = 2'b10;
    req_valid = 2'b10;
    #1;
    chk("oor_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    chk("oor_wren", 32'(wren), 32'h0);
    chk("oor_rden", 32'(rden), 32'h0);
    step();
    chk("oor_resp_valid", 32'(resp_valid), 32'h2);
    chk("oor_resp_err", 32'(resp_err), 32'h1);
    chk("oor_resp_data", resp_data, 32'h0);
    step();

    // Test 5b: write to layer 0xF (broadcast when enabled, error otherwise)
    req_addr[0] = 32'h0F00_0000;
    req_wdata[0] = 32'hBCBC_0001;
    req_wr = 2'b01;
    req_valid = 2'b01;
    #1;
    chk("bc_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("bc_wren", 32'(wren), 32'(BC_WREN));
    chk("bc_rden", 32'(rden), 32'h0);
    step();
    chk("bc_resp_valid", 32'(resp_valid), 32'h1);
    chk("bc_resp_err", 32'(resp_err), 32'(BC_ERR));
    step();

    // Test 5c: read of layer 0xF always errors with no strobe
    req_addr[1] = 32'h0F00_0000;
    req_wr = 2'b00;
    req_valid = 2'b10;
    #1;
    chk("bcr_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    chk("bcr_rden", 32'(rden), 32'h0);
    chk("bcr_wren", 32'(wren), 32'h0);
    step();
    chk("bcr_resp_valid", 32'(resp_valid), 32'h2);
    chk("bcr_resp_err", 32'(resp_err), 32'h1);
    step();

    // Test 6: reset during WAIT_RD aborts the transaction; pointer returns to 0
    req_addr[0] = 32'h0000_0000;
    req_wr = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("ar_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("ar_rden", 32'(rden), 32'h1);
    step();
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("ar_resp_valid", 32'(resp_valid), 32'h0);
    chk("ar_resp_err", 32'(resp_err), 32'h0);
    chk("ar_resp_data", resp_data, 32'h0);
    chk("ar_rden_off", 32'(rden), 32'h0);
    chk("ar_addr", rule_addr, 32'h0);
    chk("ar_wdata", rule_wdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ar_hold_resp", 32'(resp_valid), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_addr[0] = 32'h0200_0000;
    req_addr[1] = 32'h0300_0000;
    req_wdata[0] = 32'h600D_0000;
    req_wr = 2'b11;
    req_valid = 2'b11;
    #1;
    chk("ar_post_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    chk("ar_post_wren", 32'(wren), 32'h4);
    chk("ar_post_wdata", rule_wdata, 32'h600D_0000);
    step();
    chk("ar_post_resp", 32'(resp_valid), 32'h1);
    chk("ar_post_err", 32'(resp_err), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
